servile_rf_mem_arb: RTL and testbench

SERVILE_RF_MEM_ARB -- requirements
Module: servile_rf_mem_arb

---
 rtl/servile_rf_mem_arb.sv | 190 +++++++++++++++++++
 tb/tb_servile_rf_mem_arb.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servile_rf_mem_arb.sv
// servile_rf_mem_arb
//
// Purpose:
//   Shares a single 1R1W SRAM between the CPU register file and a 32-bit
//   Wishbone slave. The register file is mapped to the top of the SRAM by
//   inverting its zero-extended address. Wishbone words are split into
//   NB = 32/sram_dw narrow beats. Register-file traffic always has priority.
//   When the register file is active, the Wishbone engine holds its beat
//   until the SRAM ports are free again.
//
// Ports:
//   i_clk, i_rst             clock and synchronous active-high reset
//   i_waddr/i_wdata/i_wen    register-file write port
//   i_raddr/i_ren, o_rdata   register-file read port (register 0 reads as 0)
//   o_sram_w*                SRAM write port
//   o_sram_r*, i_sram_rdata  SRAM read port (data returns one cycle after ren)
//   i_wb_*                   Wishbone slave request (held until ack)
//   o_wb_rdt, o_wb_ack       Wishbone read data and registered acknowledge
module servile_rf_mem_arb #(
  parameter int depth   = 256,
  parameter int sram_dw = 8,
  parameter int rf_regs = 32,
  localparam int NB     = 32 / sram_dw,
  localparam int bw     = $clog2(NB),
  localparam int aw     = $clog2(depth),
  localparam int rf_aw  = $clog2(rf_regs * NB)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [rf_aw-1:0]   i_waddr,
  input  logic [sram_dw-1:0] i_wdata,
  input  logic               i_wen,
  input  logic [rf_aw-1:0]   i_raddr,
  input  logic               i_ren,
  output logic [sram_dw-1:0] o_rdata,
  output logic [aw-1:0]      o_sram_waddr,
  output logic [sram_dw-1:0] o_sram_wdata,
  output logic               o_sram_wen,
  output logic [aw-1:0]      o_sram_raddr,
  output logic               o_sram_ren,
  input  logic [sram_dw-1:0] i_sram_rdata,
  input  logic [aw-1:bw]     i_wb_adr,
  input  logic [31:0]        i_wb_dat,
  input  logic [3:0]         i_wb_sel,
  input  logic               i_wb_we,
  input  logic               i_wb_stb,
  output logic [31:0]        o_wb_rdt,
  output logic               o_wb_ack
);

  // The beat counter is kept one bit wide even when a word is a single beat.
  localparam int BCW = (bw > 0) ? bw : 1;
  localparam int CW  = aw - bw + BCW;
  localparam int BPB = sram_dw / 8;
  localparam int RZW = $clog2(rf_regs);

  typedef enum logic [1:0] {IDLE, BEAT, WAIT, ACK} state_t;

  state_t             state_q;
  logic [BCW-1:0]     beatCnt_q;
  logic [BCW-1:0]     issueBeat_q;
  logic               issueRd_q;
  logic               regZero_q;
  logic               ack_q;
  logic [31:0]        rdt_q;

  logic               wbIssue;
  logic               lastBeat;
  logic               laneMask;
  logic [sram_dw-1:0] wbWdata;
  logic [CW-1:0]      wbCat;
  logic [aw-1:0]      wbAddr;
  logic [aw-1:0]      rfWaddr;
  logic [aw-1:0]      rfRaddr;
  logic               rfTopZero;

  // The Wishbone engine may issue only when the register file leaves both
  // SRAM ports idle. Reset also blocks it so that both enables stay low.
  assign wbIssue  = (state_q == BEAT) && !i_wen && !i_ren && !i_rst;
  assign lastBeat = (beatCnt_q == BCW'(NB - 1));

  // The beat index forms the low address bits. When a word is a single beat,
  // the padding bit is dropped and only i_wb_adr remains.
  assign wbCat  = {i_wb_adr, beatCnt_q};
  assign wbAddr = wbCat[CW-1 -: aw];

  // Zero-extend and then invert, which places the register file at the top of the SRAM.
  assign rfWaddr = ~(aw'(i_waddr));
  assign rfRaddr = ~(aw'(i_raddr));

  assign rfTopZero = (i_raddr[rf_aw-1 -: RZW] == '0);

  // Select the byte lanes and data slice that belong to the current beat.
  always_comb begin
    laneMask = 1'b0;
    wbWdata  = '0;
    for (int k = 0; k < 4; k++) begin
      if ((k / BPB) == int'(beatCnt_q)) laneMask = laneMask | i_wb_sel[k];
    end
    for (int b = 0; b < NB; b++) begin
      if (beatCnt_q == BCW'(b)) wbWdata = i_wb_dat[b*sram_dw +: sram_dw];
    end
  end

  // SRAM port mux. A Wishbone beat takes both ports. Otherwise the register
  // file drives them directly.
  always_comb begin
    o_sram_waddr = rfWaddr;
    o_sram_wdata = i_wdata;
    o_sram_wen   = i_wen & ~i_rst;
    o_sram_raddr = rfRaddr;
    o_sram_ren   = i_ren & ~i_rst;
    if (wbIssue) begin
      o_sram_waddr = wbAddr;
      o_sram_wdata = wbWdata;
      o_sram_wen   = i_wb_we & laneMask;
      o_sram_raddr = wbAddr;
      o_sram_ren   = ~i_wb_we;
    end
  end

  // Control FSM. A stalled beat holds both the counter and the state.
  // Writes acknowledge right after the last beat. Reads spend one cycle in
  // WAIT so that the last beat's data can be captured.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      beatCnt_q   <= '0;
      issueBeat_q <= '0;
      issueRd_q   <= 1'b0;
      regZero_q   <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      ack_q     <= 1'b0;
      issueRd_q <= wbIssue & ~i_wb_we;
      regZero_q <= i_ren & rfTopZero;
      if (wbIssue) issueBeat_q <= beatCnt_q;
      case (state_q)
        IDLE: begin
          if (i_wb_stb) begin
            state_q   <= BEAT;
            beatCnt_q <= '0;
          end
        end
        BEAT: begin
          if (wbIssue) begin
            if (lastBeat) begin
              beatCnt_q <= '0;
              if (i_wb_we) begin
                state_q <= ACK;
                ack_q   <= 1'b1;
              end else begin
                state_q <= WAIT;
              end
            end else begin
              beatCnt_q <= beatCnt_q + 1'b1;
            end
          end
        end
        WAIT: begin
          state_q <= ACK;
          ack_q   <= 1'b1;
        end
        ACK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Read-data capture is keyed to the registered issue flag, not to the
  // state. As a result, a beat's data is still captured when the register
  // file takes the SRAM on the following cycle. Register-file reads never
  // set the flag. The register is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (issueRd_q) begin
      for (int b = 0; b < NB; b++) begin
        if (issueBeat_q == BCW'(b)) rdt_q[b*sram_dw +: sram_dw] <= i_sram_rdata;
      end
    end
  end

  assign o_wb_rdt = rdt_q;
  assign o_wb_ack = ack_q;
  assign o_rdata  = regZero_q ? '0 : i_sram_rdata;

endmodule

// File: tb/tb_servile_rf_mem_arb.sv
// Testbench for servile_rf_mem_arb.
// This bench uses two instances: a byte-wide SRAM (four beats per word) and
// a word-wide SRAM (one beat per word). Each instance has a simple 1R1W
// SRAM model with a registered read.
module tb_servile_rf_mem_arb;

  logic clk;
  int   compareCount;
  int   mismatchCount;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-wide instance signals.
  logic        aRst;
  logic [6:0]  aWaddr;
  logic [7:0]  aWdata;
  logic        aWen;
  logic [6:0]  aRaddr;
  logic        aRen;
  logic [7:0]  aRdata;
  logic [7:0]  aSramWaddr;
  logic [7:0]  aSramWdata;
  logic        aSramWen;
  logic [7:0]  aSramRaddr;
  logic        aSramRen;
  logic [7:0]  aSramRdata;
  logic [7:2]  aWbAdr;
  logic [31:0] aWbDat;
  logic [3:0]  aWbSel;
  logic        aWbWe;
  logic        aWbStb;
  logic [31:0] aWbRdt;
  logic        aWbAck;

  // Word-wide instance signals.
  logic        bRst;
  logic [4:0]  bWaddr;
  logic [31:0] bWdata;
  logic        bWen;
  logic [4:0]  bRaddr;
  logic        bRen;
  logic [31:0] bRdata;
  logic [7:0]  bSramWaddr;
  logic [31:0] bSramWdata;
  logic        bSramWen;
  logic [7:0]  bSramRaddr;
  logic        bSramRen;
  logic [31:0] bSramRdata;
  logic [7:0]  bWbAdr;
  logic [31:0] bWbDat;
  logic [3:0]  bWbSel;
  logic        bWbWe;
  logic        bWbStb;
  logic [31:0] bWbRdt;
  logic        bWbAck;

  servile_rf_mem_arb #(.depth(256), .sram_dw(8), .rf_regs(32)) dutA (
    .i_clk(clk), .i_rst(aRst),
    .i_waddr(aWaddr), .i_wdata(aWdata), .i_wen(aWen),
    .i_raddr(aRaddr), .i_ren(aRen), .o_rdata(aRdata),
    .o_sram_waddr(aSramWaddr), .o_sram_wdata(aSramWdata), .o_sram_wen(aSramWen),
    .o_sram_raddr(aSramRaddr), .o_sram_ren(aSramRen), .i_sram_rdata(aSramRdata),
    .i_wb_adr(aWbAdr), .i_wb_dat(aWbDat), .i_wb_sel(aWbSel), .i_wb_we(aWbWe),
    .i_wb_stb(aWbStb), .o_wb_rdt(aWbRdt), .o_wb_ack(aWbAck)
  );

  servile_rf_mem_arb #(.depth(256), .sram_dw(32), .rf_regs(32)) dutB (
    .i_clk(clk), .i_rst(bRst),
    .i_waddr(bWaddr), .i_wdata(bWdata), .i_wen(bWen),
    .i_raddr(bRaddr), .i_ren(bRen), .o_rdata(bRdata),
    .o_sram_waddr(bSramWaddr), .o_sram_wdata(bSramWdata), .o_sram_wen(bSramWen),
    .o_sram_raddr(bSramRaddr), .o_sram_ren(bSramRen), .i_sram_rdata(bSramRdata),
    .i_wb_adr(bWbAdr), .i_wb_dat(bWbDat), .i_wb_sel(bWbSel), .i_wb_we(bWbWe),
    .i_wb_stb(bWbStb), .o_wb_rdt(bWbRdt), .o_wb_ack(bWbAck)
  );

  // SRAM models: synchronous write, registered read.
  logic [7:0]  memA [0:255];
  logic [31:0] memB [0:255];

  always @(posedge clk) begin
    if (aSramWen) memA[aSramWaddr] <= aSramWdata;
    if (aSramRen) aSramRdata <= memA[aSramRaddr];
    if (bSramWen) memB[bSramWaddr] <= bSramWdata;
    if (bSramRen) bSramRdata <= memB[bSramRaddr];
  end

  // Per-cycle record of the byte-wide instance during one transaction.
  logic        recWen   [0:11];
  logic        recRen   [0:11];
  logic [7:0]  recWaddr [0:11];
  logic [7:0]  recWdata [0:11];
  logic [7:0]  recRaddr [0:11];
  logic [31:0] recRdt   [0:11];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one Wishbone transaction on the byte-wide instance for a fixed
  // 12-cycle window. Cycle 0 is the first cycle with stb high in IDLE.
  // An optional RF read (raddr 0x11) stalls the engine in cycles
  // [stallStart, stallStart+stallLen). An optional reset pulse is applied at
  // rstCycle, and the strobe is dropped from that cycle on.
  task automatic applyStimulus(input logic [5:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input logic we,
                               input int stallStart, input int stallLen,
                               input int rstCycle,
                               output int ackCycle, output int ackCount);
    bit done;
    done     = 1'b0;
    ackCycle = -1;
    ackCount = 0;
    for (int c = 0; c < 12; c++) begin
      aWbAdr = adr;
      aWbDat = dat;
      aWbSel = sel;
      aWbWe  = we;
      aWbStb = !done && !(rstCycle >= 0 && c >= rstCycle);
      aRen   = (c >= stallStart) && (c < stallStart + stallLen);
      aRaddr = 7'h11;
      aRst   = (c == rstCycle);
      @(negedge clk);
      recWen[c]   = aSramWen;
      recRen[c]   = aSramRen;
      recWaddr[c] = aSramWaddr;
      recWdata[c] = aSramWdata;
      recRaddr[c] = aSramRaddr;
      recRdt[c]   = aWbRdt;
      if (aWbAck) begin
        ackCount++;
        if (ackCycle < 0) ackCycle = c;
      end
      @(posedge clk);
      #1;
      if (ackCycle >= 0) done = 1'b1;
    end
    aWbStb = 1'b0;
    aRen   = 1'b0;
    aRst   = 1'b0;
  endtask

  initial begin
    int ack;
    int cnt;
    logic [7:0] expB [0:3];
    compareCount  = 0;
    mismatchCount = 0;

    aRst = 1'b1; aWaddr = 7'h7F; aWdata = 8'h5A; aWen = 1'b1;
    aRaddr = 7'h00; aRen = 1'b1;
    aWbAdr = '0; aWbDat = '0; aWbSel = '0; aWbWe = 1'b0; aWbStb = 1'b0;
    bRst = 1'b1; bWaddr = '0; bWdata = '0; bWen = 1'b0; bRaddr = '0; bRen = 1'b0;
    bWbAdr = '0; bWbDat = '0; bWbSel = '0; bWbWe = 1'b0; bWbStb = 1'b0;

    // During reset, both SRAM enables are forced low, even with RF requests present.
    @(negedge clk);
    checkOutput("rst_ack", 32'(aWbAck), 32'd0);
    checkOutput("rst_wen", 32'(aSramWen), 32'd0);
    checkOutput("rst_ren", 32'(aSramRen), 32'd0);
    checkOutput("rst_ackB", 32'(bWbAck), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    aRst = 1'b0; aWen = 1'b0; aRen = 1'b0; bRst = 1'b0;
    @(posedge clk); #1;
    $display("[TB] reset released");

    // Four-beat write of 0x44332211 to word 0x05, targeting bytes 0x14..0x17.
    expB[0] = 8'h11; expB[1] = 8'h22; expB[2] = 8'h33; expB[3] = 8'h44;
    applyStimulus(6'h05, 32'h44332211, 4'hF, 1'b1, -1, 0, -1, ack, cnt);
    checkOutput("wr_ack_cycle", 32'(ack), 32'd5);
    checkOutput("wr_ack_count", 32'(cnt), 32'd1);
    checkOutput("wr_idle_wen", 32'(recWen[0]), 32'd0);
    for (int b = 0; b < 4; b++) begin
      checkOutput("wr_beat_wen", 32'(recWen[b+1]), 32'd1);
      checkOutput("wr_beat_addr", 32'(recWaddr[b+1]), 32'(8'h14 + b));
      checkOutput("wr_beat_data", 32'(recWdata[b+1]), 32'(expB[b]));
    end

    // Read back the same word. The read takes one extra cycle for WAIT.
    applyStimulus(6'h05, 32'h0, 4'hF, 1'b0, -1, 0, -1, ack, cnt);
    checkOutput("rd_ack_cycle", 32'(ack), 32'd6);
    checkOutput("rd_ack_count", 32'(cnt), 32'd1);
    checkOutput("rd_beat0_ren", 32'(recRen[1]), 32'd1);
    checkOutput("rd_beat0_addr", 32'(recRaddr[1]), 32'h14);
    checkOutput("rd_data", recRdt[6], 32'h44332211);

    // sel=0x5 writes only beats 0 and 2. Beats 1 and 3 still take a cycle each.
    applyStimulus(6'h06, 32'hDDCCBBAA, 4'h5, 1'b1, -1, 0, -1, ack, cnt);
    checkOutput("sel5_ack_cycle", 32'(ack), 32'd5);
    checkOutput("sel5_wen_b0", 32'(recWen[1]), 32'd1);
    checkOutput("sel5_wen_b1", 32'(recWen[2]), 32'd0);
    checkOutput("sel5_wen_b2", 32'(recWen[3]), 32'd1);
    checkOutput("sel5_wen_b3", 32'(recWen[4]), 32'd0);
    checkOutput("sel5_mem18", 32'(memA[8'h18]), 32'hAA);
    checkOutput("sel5_mem1a", 32'(memA[8'h1A]), 32'hCC);

    // An RF read in cycles 2..3 preempts beat 1, pushing it to cycle 4.
    applyStimulus(6'h05, 32'h0, 4'hF, 1'b0, 2, 2, -1, ack, cnt);
    checkOutput("stall_ack_cycle", 32'(ack), 32'd8);
    checkOutput("stall_raddr_c2", 32'(recRaddr[2]), 32'hEE);
    checkOutput("stall_raddr_c3", 32'(recRaddr[3]), 32'hEE);
    checkOutput("stall_ren_c2", 32'(recRen[2]), 32'd1);
    checkOutput("stall_beat1_addr", 32'(recRaddr[4]), 32'h15);
    checkOutput("stall_data", recRdt[8], 32'h44332211);

    // Write a fresh word, then abort a read of it with a reset pulse.
    applyStimulus(6'h07, 32'h88776655, 4'hF, 1'b1, -1, 0, -1, ack, cnt);
    checkOutput("w07_ack_cycle", 32'(ack), 32'd5);
    applyStimulus(6'h07, 32'h0, 4'hF, 1'b0, -1, 0, 3, ack, cnt);
    checkOutput("rstmid_ack_count", 32'(cnt), 32'd0);
    checkOutput("rstmid_ren_c2", 32'(recRen[2]), 32'd1);
    checkOutput("rstmid_ren_c3", 32'(recRen[3]), 32'd0);
    checkOutput("rstmid_wen_c3", 32'(recWen[3]), 32'd0);
    checkOutput("rstmid_idle_c4", 32'(recRen[4]), 32'd0);
    applyStimulus(6'h07, 32'h0, 4'hF, 1'b0, -1, 0, -1, ack, cnt);
    checkOutput("reissue_ack_cycle", 32'(ack), 32'd6);
    checkOutput("reissue_data", recRdt[6], 32'h88776655);

    // RF write/read. Register 0 reads as zero, and raddr 0x7F maps to SRAM byte 0x80.
    aWen = 1'b1; aWaddr = 7'h7F; aWdata = 8'hA5;
    @(negedge clk);
    checkOutput("rf_wen", 32'(aSramWen), 32'd1);
    checkOutput("rf_waddr", 32'(aSramWaddr), 32'h80);
    checkOutput("rf_wdata", 32'(aSramWdata), 32'hA5);
    @(posedge clk); #1;
    aWen = 1'b0; aRen = 1'b1; aRaddr = 7'h02;
    @(negedge clk);
    checkOutput("rf_raddr", 32'(aSramRaddr), 32'hFD);
    checkOutput("rf_ren", 32'(aSramRen), 32'd1);
    @(posedge clk); #1;
    aRaddr = 7'h7F;
    @(negedge clk);
    checkOutput("rf_reg0_zero", 32'(aRdata), 32'h00);
    @(posedge clk); #1;
    aRen = 1'b0;
    @(negedge clk);
    checkOutput("rf_top_byte", 32'(aRdata), 32'hA5);
    checkOutput("rf_wb_rdt_held", aWbRdt, 32'h88776655);
    @(posedge clk); #1;

    // Word-wide SRAM: each access is a single beat.
    begin
      int bAck;
      bit bDone;
      for (int pass = 0; pass < 2; pass++) begin
        bAck  = -1;
        bDone = 1'b0;
        for (int c = 0; c < 8; c++) begin
          bWbAdr = 8'h21;
          bWbDat = 32'hCAFEF00D;
          bWbSel = 4'hF;
          bWbWe  = (pass == 0);
          bWbStb = !bDone;
          @(negedge clk);
          if (bWbAck && bAck < 0) bAck = c;
          if (bAck == c && pass == 1) checkOutput("w32_rd_data", bWbRdt, 32'hCAFEF00D);
          @(posedge clk); #1;
          if (bAck >= 0) bDone = 1'b1;
        end
        bWbStb = 1'b0;
        if (pass == 0) begin
          checkOutput("w32_wr_ack_cycle", 32'(bAck), 32'd2);
          checkOutput("w32_mem", memB[8'h21], 32'hCAFEF00D);
        end else begin
          checkOutput("w32_rd_ack_cycle", 32'(bAck), 32'd3);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
